// File: rtl/cache_pkg.sv
// Shared types and geometry for the 2-way set-associative cache controller.
package cache_pkg;

   localparam int S_OFFSET = 5;
   localparam int S_INDEX  = 3;
   localparam int NUM_SETS = 2 ** S_INDEX;
   localparam int S_TAG    = 32 - S_OFFSET - S_INDEX;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      COMPARE   = 2'd1,
      WRITEBACK = 2'd2,
      ALLOCATE  = 2'd3
   } state_e;

   typedef struct packed {
      logic [S_TAG-1:0]    tag;
      logic [S_INDEX-1:0]  index;
      logic [S_OFFSET-1:0] offset;
   } addr_t;

endpackage

// File: rtl/cache_if.sv
// CPU, datapath-status/enable and memory handshake bundle of the cache controller.
interface cache_if;

   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic        cpu_resp;
   logic        busy;
   logic [1:0]  isHit;
   logic [1:0]  isValid;
   logic [1:0]  isDirty;
   logic [1:0]  writeEn;
   logic        fillSel;
   logic [1:0]  setValid;
   logic [1:0]  writeValid;
   logic [1:0]  setDirty;
   logic [1:0]  writeDirty;
   logic        wbWay;
   logic        mem_read;
   logic        mem_write;
   logic        mem_resp;

   modport master (
      input  cpu_req, cpu_we, cpu_addr, isHit, isValid, isDirty, mem_resp,
      output cpu_resp, busy, writeEn, fillSel, setValid, writeValid,
             setDirty, writeDirty, wbWay, mem_read, mem_write
   );

   modport slave (
      output cpu_req, cpu_we, cpu_addr, isHit, isValid, isDirty, mem_resp,
      input  cpu_resp, busy, writeEn, fillSel, setValid, writeValid,
             setDirty, writeDirty, wbWay, mem_read, mem_write
   );

endinterface

// File: rtl/lru_array.sv
// Per-set LRU bit store: value is the way to evict next; combinational read.
module lru_array #(
   parameter int NUM_SETS = 8,
   parameter int IDX_W    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we_i,
   input  logic [IDX_W-1:0] waddr_i,
   input  logic             wdata_i,
   input  logic [IDX_W-1:0] raddr_i,
   output logic             rdata_o
);

   logic [NUM_SETS-1:0] lru_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lru_q <= '0;
      end else if (we_i) begin
         lru_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = lru_q[raddr_i];

endmodule

// File: rtl/cache_controller.sv
// Control FSM for the 2-way set-associative cache: hit/miss, write-back, line fill, LRU.
// Optional CACHE_PERF_CNT_EN adds hitCount/missCount outputs.
module cache_controller
   import cache_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   cache_if.master     bus
`ifdef CACHE_PERF_CNT_EN
   ,
   output logic [31:0] hitCount,
   output logic [31:0] missCount
`endif
);

   state_e               state_q, state_d;
   logic                 victim_q, victim_d;
   addr_t                addr;
   logic [S_INDEX-1:0]   idx;
   logic                 unused_addr;
   logic                 lru_rd, lru_we, lru_wdata;
   logic                 hit0, hit1, hit, hit_way, victim_sel;
   logic [1:0]           write_en, set_valid, write_valid, set_dirty, write_dirty;
   logic                 fill_sel, cpu_resp, mem_read, mem_write, wb_way;

   assign addr        = addr_t'(bus.cpu_addr);
   assign idx         = addr.index;
   assign unused_addr = ^{addr.tag, addr.offset};

   // A tag match only counts when that way is valid; a double hit resolves to way 0.
   assign hit0       = bus.isHit[0] & bus.isValid[0];
   assign hit1       = bus.isHit[1] & bus.isValid[1];
   assign hit        = hit0 | hit1;
   assign hit_way    = ~hit0;
   assign victim_sel = ~bus.isValid[0] ? 1'b0 :
                       ~bus.isValid[1] ? 1'b1 : lru_rd;

   lru_array #(
      .NUM_SETS (NUM_SETS),
      .IDX_W    (S_INDEX)
   ) u_lru (
      .clk     (clk),
      .rst     (rst),
      .we_i    (lru_we),
      .waddr_i (idx),
      .wdata_i (lru_wdata),
      .raddr_i (idx),
      .rdata_o (lru_rd)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         victim_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         victim_q <= victim_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      victim_d    = victim_q;
      lru_we      = 1'b0;
      lru_wdata   = 1'b0;
      write_en    = 2'b00;
      set_valid   = 2'b00;
      write_valid = 2'b00;
      set_dirty   = 2'b00;
      write_dirty = 2'b00;
      fill_sel    = 1'b0;
      cpu_resp    = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      wb_way      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.cpu_req) state_d = COMPARE;
         end
         COMPARE: begin
            if (hit) begin
               cpu_resp  = 1'b1;
               lru_we    = 1'b1;
               lru_wdata = ~hit_way;
               if (bus.cpu_we) begin
                  write_en[hit_way]    = 1'b1;
                  set_dirty[hit_way]   = 1'b1;
                  write_dirty[hit_way] = 1'b1;
               end
               state_d = IDLE;
            end else begin
               victim_d = victim_sel;
               if (bus.isValid[victim_sel] && bus.isDirty[victim_sel])
                  state_d = WRITEBACK;
               else
                  state_d = ALLOCATE;
            end
         end
         WRITEBACK: begin
            mem_write = 1'b1;
            wb_way    = victim_q;
            if (bus.mem_resp) begin
               write_dirty[victim_q] = 1'b1;
               state_d               = ALLOCATE;
            end
         end
         ALLOCATE: begin
            mem_read = 1'b1;
            if (bus.mem_resp) begin
               write_en[victim_q]    = 1'b1;
               fill_sel              = 1'b1;
               set_valid[victim_q]   = 1'b1;
               write_valid[victim_q] = 1'b1;
               write_dirty[victim_q] = 1'b1;
               state_d               = COMPARE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.cpu_resp   = cpu_resp;
   assign bus.busy       = (state_q != IDLE);
   assign bus.writeEn    = write_en;
   assign bus.fillSel    = fill_sel;
   assign bus.setValid   = set_valid;
   assign bus.writeValid = write_valid;
   assign bus.setDirty   = set_dirty;
   assign bus.writeDirty = write_dirty;
   assign bus.wbWay      = wb_way;
   assign bus.mem_read   = mem_read;
   assign bus.mem_write  = mem_write;

`ifdef CACHE_PERF_CNT_EN
   // Only a COMPARE entered straight from IDLE is a fresh lookup; post-fill re-lookups are not.
   logic        fresh_q;
   logic [31:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fresh_q    <= 1'b0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         fresh_q <= (state_q == IDLE);
         if (state_q == COMPARE && fresh_q) begin
            if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
            else     miss_cnt_q <= miss_cnt_q + 32'd1;
         end
      end
   end

   assign hitCount  = hit_cnt_q;
   assign missCount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural datapath/memory model; define CACHE_PERF_CNT_EN to also check counters.
module tb_cache_controller;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   hit_exp;
   int   miss_exp;
   bit   init_dp;

   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   cache_if bus ();

`ifdef CACHE_PERF_CNT_EN
   cache_controller dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .hitCount  (hit_cnt),
      .missCount (miss_cnt)
   );
`else
   cache_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
   assign hit_cnt  = 32'd0;
   assign miss_cnt = 32'd0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural datapath: tag/valid/dirty per set and way, written by the controller enables.
   logic [23:0] tag_m [0:7][0:1];
   logic        val_m [0:7][0:1];
   logic        dty_m [0:7][0:1];
   logic [2:0]  m_idx;
   logic [23:0] m_tag;

   assign m_idx = bus.cpu_addr[7:5];
   assign m_tag = bus.cpu_addr[31:8];

   always_comb begin
      bus.isHit   = 2'b00;
      bus.isValid = 2'b00;
      bus.isDirty = 2'b00;
      for (int w = 0; w < 2; w++) begin
         bus.isHit[w]   = (tag_m[m_idx][w] == m_tag);
         bus.isValid[w] = val_m[m_idx][w];
         bus.isDirty[w] = dty_m[m_idx][w];
      end
   end

   always @(posedge clk) begin
      for (int s = 0; s < 8; s++) begin
         for (int w = 0; w < 2; w++) begin
            if (init_dp) begin
               tag_m[s][w] <= (w == 0) ? 24'h000000 : 24'hFFFFFF;
               val_m[s][w] <= 1'b0;
               dty_m[s][w] <= 1'b0;
            end else if (s == int'(m_idx)) begin
               if (bus.writeEn[w])    tag_m[s][w] <= m_tag;
               if (bus.writeValid[w]) val_m[s][w] <= bus.setValid[w];
               if (bus.writeDirty[w]) dty_m[s][w] <= bus.setDirty[w];
            end
         end
      end
   end

   // Continuous protocol monitor: no simultaneous memory requests, no double valid hit.
   always @(negedge clk) begin
      if (!rst && !init_dp) begin
         checks++;
         assert (!(bus.mem_read && bus.mem_write) &&
                 !(bus.busy && bus.isHit == 2'b11 && bus.isValid == 2'b11))
         else begin
            errors++;
            $error("FAIL protocol observed rd=%0b wr=%0b hit=%b valid=%b required no overlap/no double hit",
                   bus.mem_read, bus.mem_write, bus.isHit, bus.isValid);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One CPU request from IDLE; miss path uses a memory that acks on its third request cycle.
   task automatic access(input string tag, input logic [31:0] a, input logic we,
                         input bit hit, input bit way, input bit wb);
      logic [1:0] wv;
      wv = way ? 2'b10 : 2'b01;
      bus.cpu_addr = a;
      bus.cpu_we   = we;
      bus.cpu_req  = 1'b1;
      #1;
      chk({tag, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
      tick();
      chk({tag, "_cmp_busy"}, {31'd0, bus.busy}, 32'd1);
      if (!hit) begin
         miss_exp++;
         chk({tag, "_miss_resp"}, {31'd0, bus.cpu_resp}, 32'd0);
         chk({tag, "_miss_we"}, {30'd0, bus.writeEn}, 32'd0);
         tick();
         if (wb) begin
            chk({tag, "_wb_wr"}, {31'd0, bus.mem_write}, 32'd1);
            chk({tag, "_wb_rd"}, {31'd0, bus.mem_read}, 32'd0);
            chk({tag, "_wb_way"}, {31'd0, bus.wbWay}, {31'd0, way});
            tick();
            tick();
            bus.mem_resp = 1'b1;
            #1;
            chk({tag, "_wb_wdirty"}, {30'd0, bus.writeDirty}, {30'd0, wv});
            chk({tag, "_wb_sdirty"}, {30'd0, bus.setDirty}, 32'd0);
            chk({tag, "_wb_we"}, {30'd0, bus.writeEn}, 32'd0);
            tick();
            bus.mem_resp = 1'b0;
            #1;
         end
         chk({tag, "_al_rd"}, {31'd0, bus.mem_read}, 32'd1);
         chk({tag, "_al_wr"}, {31'd0, bus.mem_write}, 32'd0);
         chk({tag, "_al_nowe"}, {30'd0, bus.writeEn}, 32'd0);
         tick();
         tick();
         bus.mem_resp = 1'b1;
         #1;
         chk({tag, "_fill_we"}, {30'd0, bus.writeEn}, {30'd0, wv});
         chk({tag, "_fill_sel"}, {31'd0, bus.fillSel}, 32'd1);
         chk({tag, "_fill_sval"}, {30'd0, bus.setValid}, {30'd0, wv});
         chk({tag, "_fill_wval"}, {30'd0, bus.writeValid}, {30'd0, wv});
         chk({tag, "_fill_wdty"}, {30'd0, bus.writeDirty}, {30'd0, wv});
         chk({tag, "_fill_sdty"}, {30'd0, bus.setDirty}, 32'd0);
         tick();
         bus.mem_resp = 1'b0;
         #1;
      end else begin
         hit_exp++;
      end
      chk({tag, "_resp"}, {31'd0, bus.cpu_resp}, 32'd1);
      chk({tag, "_hit_we"}, {30'd0, bus.writeEn}, we ? {30'd0, wv} : 32'd0);
      chk({tag, "_hit_sdty"}, {30'd0, bus.setDirty}, we ? {30'd0, wv} : 32'd0);
      chk({tag, "_hit_wdty"}, {30'd0, bus.writeDirty}, we ? {30'd0, wv} : 32'd0);
      chk({tag, "_hit_sel"}, {31'd0, bus.fillSel}, 32'd0);
      chk({tag, "_hit_wval"}, {30'd0, bus.writeValid}, 32'd0);
      tick();
      bus.cpu_req = 1'b0;
      #1;
      chk({tag, "_done_resp"}, {31'd0, bus.cpu_resp}, 32'd0);
      chk({tag, "_done_busy"}, {31'd0, bus.busy}, 32'd0);
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      hit_exp      = 0;
      miss_exp     = 0;
      init_dp      = 1'b1;
      rst          = 1'b1;
      bus.cpu_req  = 1'b0;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 32'd0;
      bus.mem_resp = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_resp", {31'd0, bus.cpu_resp}, 32'd0);
      chk("rst_rd", {31'd0, bus.mem_read}, 32'd0);
      chk("rst_wr", {31'd0, bus.mem_write}, 32'd0);
      chk("rst_we", {30'd0, bus.writeEn}, 32'd0);
      chk("rst_wdty", {30'd0, bus.writeDirty}, 32'd0);
`ifdef CACHE_PERF_CNT_EN
      chk("rst_hitcnt", hit_cnt, 32'd0);
      chk("rst_misscnt", miss_cnt, 32'd0);
`endif
      rst     = 1'b0;
      init_dp = 1'b0;
      tick();

      // Cold load, store hit, then fill both ways of set 2 and force a dirty eviction of way 0
      access("t1_cold", 32'h0000_0040, 1'b0, 1'b0, 1'b0, 1'b0);
      access("t2_store", 32'h0000_0044, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("t2_lru2", {31'd0, dut.u_lru.lru_q[2]}, 32'd1);
      access("t3_fill1", 32'h0000_0140, 1'b0, 1'b0, 1'b1, 1'b0);
      access("t3_dirty1", 32'h0000_0140, 1'b1, 1'b1, 1'b1, 1'b0);
      access("t3_evict", 32'h0000_0240, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef CACHE_PERF_CNT_EN
      chk("t3_hitcnt", hit_cnt, hit_exp[31:0]);
      chk("t3_misscnt", miss_cnt, miss_exp[31:0]);
`endif

      // Reset during a line fill drops mem_read immediately
      bus.cpu_addr = 32'h0000_0060;
      bus.cpu_we   = 1'b0;
      bus.cpu_req  = 1'b1;
      tick();
      tick();
      chk("t4_rd_before", {31'd0, bus.mem_read}, 32'd1);
      rst = 1'b1;
      #1;
      chk("t4_rd_drop", {31'd0, bus.mem_read}, 32'd0);
      chk("t4_wr_drop", {31'd0, bus.mem_write}, 32'd0);
      chk("t4_busy", {31'd0, bus.busy}, 32'd0);
      bus.cpu_req = 1'b0;
      hit_exp     = 0;
      miss_exp    = 0;
      tick();
      rst = 1'b0;
      #1;
      // LRU back to 0: set 2 evicts clean way 0 instead of dirty way 1
      access("t4_cold_lru", 32'h0000_0340, 1'b0, 1'b0, 1'b0, 1'b0);

      // Spurious mem_resp in IDLE and COMPARE
      bus.mem_resp = 1'b1;
      #1;
      chk("t5_idle_we", {30'd0, bus.writeEn}, 32'd0);
      chk("t5_idle_wval", {30'd0, bus.writeValid}, 32'd0);
      chk("t5_idle_wdty", {30'd0, bus.writeDirty}, 32'd0);
      tick();
      chk("t5_idle_busy", {31'd0, bus.busy}, 32'd0);
      bus.cpu_addr = 32'h0000_0340;
      bus.cpu_we   = 1'b0;
      bus.cpu_req  = 1'b1;
      tick();
      hit_exp++;
      chk("t5_cmp_resp", {31'd0, bus.cpu_resp}, 32'd1);
      chk("t5_cmp_sel", {31'd0, bus.fillSel}, 32'd0);
      chk("t5_cmp_wval", {30'd0, bus.writeValid}, 32'd0);
      chk("t5_cmp_we", {30'd0, bus.writeEn}, 32'd0);
      chk("t5_cmp_rd", {31'd0, bus.mem_read}, 32'd0);
      tick();
      bus.cpu_req  = 1'b0;
      bus.mem_resp = 1'b0;
      #1;
      chk("t5_end_busy", {31'd0, bus.busy}, 32'd0);
`ifdef CACHE_PERF_CNT_EN
      chk("t6_hitcnt", hit_cnt, hit_exp[31:0]);
      chk("t6_misscnt", miss_cnt, miss_exp[31:0]);
`endif

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
